aes_word_seq: RTL

Word-serial sequencer between the system's 128-bit block interface and the 32-bit word port of the AES core. It accepts one 128-bit key and one 128-bit plaintext block on a valid/ready handshake and streams them to the core as four 32-bit beats under `ld`. It then collects the four 32-bit `text_out` beats that the core returns under `done`, and presents the reassembled 128-bit result downstream on a valid/ready handshake. A watchdog flags a core that never answers.

---
 rtl/aes_word_seq.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_word_seq.sv
// -----------------------------------------------------------------------------
// aes_word_seq
//
// Word-serial sequencer that sits between a 128-bit block interface and the
// 32-bit word port of an AES core.
//
// Flow:
//   1. A key/plaintext pair is accepted on a valid/ready handshake.
//   2. It is streamed to the core as four 32-bit beats under core_ld_o,
//      most significant word first.
//   3. The four result beats returned under core_done_i are collected.
//   4. The reassembled 128-bit block is held downstream until out_ready_i.
//
// A watchdog aborts the block if the core does not answer in time. A result
// burst that ends early is also aborted. An aborted block is still presented
// downstream, but with out_err_o = 1 and out_data_o = 0.
//
// Parameters:
//   TIMEOUT_CYCLES   WAIT cycles without core_done_i before aborting
//                    (legal range 1..1023).
//
// Ports:
//   clk_i            clock; all state changes on its rising edge
//   rst_i            synchronous active-high reset
//   in_valid_i       a key/plaintext block is offered
//   in_ready_o       the sequencer can accept a block (high only in IDLE)
//   in_key_i         128-bit key, word 0 = [127:96]
//   in_text_i        128-bit plaintext, word 0 = [127:96]
//   out_valid_o      a result is held
//   out_ready_i      downstream accepts the result
//   out_data_o       128-bit ciphertext, word 0 = [127:96]
//   out_err_o        1 = aborted block (out_data_o is then 0)
//   core_ld_o        load strobe to the core, high for exactly 4 cycles
//   core_key_o       key word to the core (0 outside LOAD)
//   core_text_in_o   text word to the core (0 outside LOAD)
//   core_done_i      result beat valid from the core
//   core_text_out_i  result word from the core
//
// Every output is driven straight from a flop. There is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module aes_word_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_key_i,
  input  logic [127:0] in_text_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         out_err_o,
  output logic         core_ld_o,
  output logic [31:0]  core_key_o,
  output logic [31:0]  core_text_in_o,
  input  logic         core_done_i,
  input  logic [31:0]  core_text_out_i
);

  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // Select 32-bit word idx of a 128-bit block, word 0 being the MSW.
  function automatic logic [31:0] word_sel(input logic [127:0] blk,
                                           input logic [1:0]   idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  state_e        state_q,     state_d;
  logic [1:0]    beat_q,      beat_d;
  logic [9:0]    tmo_q,       tmo_d;
  logic [127:0]  key_q,       key_d;
  logic [127:0]  text_q,      text_d;
  // Words 0..2 of the result. Word 3 goes straight into out_data.
  logic [95:0]   res_q,       res_d;
  logic [127:0]  out_data_q,  out_data_d;
  logic          out_err_q,   out_err_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q,  in_ready_d;
  logic          core_ld_q,   core_ld_d;
  logic [31:0]   core_key_q,  core_key_d;
  logic [31:0]   core_text_q, core_text_d;

  // Next-state logic for the sequencer FSM, its counters and its datapath.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    key_d      = key_q;
    text_d     = text_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          key_d   = in_key_i;
          text_d  = in_text_i;
          beat_d  = 2'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // The beat counter wraps 3 -> 0, so it is back at 0 when WAIT starts.
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          tmo_d   = 10'd0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_WAIT: begin
        tmo_d = tmo_q + 10'd1;
        if (core_done_i) begin
          res_d[95:64] = core_text_out_i;
          beat_d       = 2'd1;
          state_d      = ST_COLLECT;
        end else if (tmo_q == TMO_LIMIT) begin
          // Checking the registered count gives TIMEOUT_CYCLES+1 WAIT
          // cycles in total, so out_valid rises TIMEOUT_CYCLES+1 cycles
          // after WAIT entry.
          out_data_d = 128'd0;
          out_err_d  = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_COLLECT: begin
        if (!core_done_i) begin
          // The burst ended before word 3. Discard the partial result.
          out_data_d = 128'd0;
          out_err_d  = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          beat_d = beat_q + 2'd1;
          case (beat_q)
            2'd1: begin
              res_d[63:32] = core_text_out_i;
              state_d      = ST_COLLECT;
            end
            2'd2: begin
              res_d[31:0] = core_text_out_i;
              state_d     = ST_COLLECT;
            end
            2'd3: begin
              out_data_d = {res_q, core_text_out_i};
              out_err_d  = 1'b0;
              state_d    = ST_HOLD;
            end
            default: begin
              // Beat 0 is never valid here. Treat it as a protocol error.
              out_data_d = 128'd0;
              out_err_d  = 1'b1;
              state_d    = ST_HOLD;
            end
          endcase
        end
      end

      ST_HOLD: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The outputs are registered copies of values decoded from the next
    // state, so each one lines up with the cycle its state is entered.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
    if (state_d == ST_LOAD) begin
      core_ld_d   = 1'b1;
      core_key_d  = word_sel(key_d, beat_d);
      core_text_d = word_sel(text_d, beat_d);
    end else begin
      core_ld_d   = 1'b0;
      core_key_d  = 32'h0000_0000;
      core_text_d = 32'h0000_0000;
    end
  end

  // State, datapath and output registers, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      beat_q      <= 2'd0;
      tmo_q       <= 10'd0;
      key_q       <= 128'd0;
      text_q      <= 128'd0;
      res_q       <= 96'd0;
      out_data_q  <= 128'd0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      core_ld_q   <= 1'b0;
      core_key_q  <= 32'h0000_0000;
      core_text_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      key_q       <= key_d;
      text_q      <= text_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      core_ld_q   <= core_ld_d;
      core_key_q  <= core_key_d;
      core_text_q <= core_text_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_err_o      = out_err_q;
  assign core_ld_o      = core_ld_q;
  assign core_key_o     = core_key_q;
  assign core_text_in_o = core_text_q;

endmodule
